// File: rtl/mult_pkg.sv
// Shared widths, the stage-1 register layout and the sticky reduction helper
// for the multiplier's final carry-propagate adder.
package mult_pkg;

    localparam int MULT_W     = 64;
    localparam int MULT_SPLIT = 32;
    localparam int MULT_HI_W  = MULT_W - MULT_SPLIT;

    typedef struct packed {
        logic [MULT_SPLIT-1:0] lo;
        logic                  c1;
        logic [MULT_HI_W-1:0]  hi_s;
        logic [MULT_HI_W-1:0]  hi_c;
    } cpa_s1_t;

    // OR of the n least significant bits of the low partial sum
    function automatic logic sticky_or(input logic [MULT_SPLIT-1:0] lo, input int unsigned n);
        logic acc;
        acc = 1'b0;
        for (int unsigned i = 0; i < MULT_SPLIT; i++) begin
            if (i < n) begin
                acc = acc | lo[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/cpa_slice.sv
// Combinational N-bit adder slice with carry in and carry out.
module cpa_slice #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mult_final_cpa.sv
// Two-stage pipelined final CPA resolving sum/carry vectors into a binary product.
// Optional sticky output is built only when MULT_CPA_STICKY_EN is defined.
module mult_final_cpa
    import mult_pkg::*;
#(
    parameter int W        = MULT_W,
    parameter int SPLIT    = MULT_SPLIT,
    parameter int STICKY_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         out_sticky
);

    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    cpa_s1_t          s1_q, s1_d;
    logic [W-1:0]     prod_q, prod_d;
    logic             s2_adv_s;
    logic             in_accept_s;
    logic [SPLIT-1:0] lo_sum_s;
    logic             lo_cout_s;
    logic [W-SPLIT-1:0] hi_sum_s;
    logic             hi_cout_unused_s;

    cpa_slice #(.N(SPLIT)) u_lo_slice (
        .a    (in_sum[SPLIT-1:0]),
        .b    (in_carry[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_s),
        .cout (lo_cout_s)
    );

    // Carry out of the top bit is the dropped 2^W term
    cpa_slice #(.N(W - SPLIT)) u_hi_slice (
        .a    (s1_q.hi_s),
        .b    (s1_q.hi_c),
        .cin  (s1_q.c1),
        .sum  (hi_sum_s),
        .cout (hi_cout_unused_s)
    );

    assign s2_adv_s    = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready    = !s1_valid_q || s2_adv_s;
    assign in_accept_s = in_valid && in_ready;

    // Valid-flag next state and stage data next values
    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (in_accept_s) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_adv_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        s1_d.lo   = lo_sum_s;
        s1_d.c1   = lo_cout_s;
        s1_d.hi_s = in_sum[W-1:SPLIT];
        s1_d.hi_c = in_carry[W-1:SPLIT];
        prod_d    = {hi_sum_s, s1_q.lo};
    end

    // Pipeline registers; data loads only on its own enable
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            prod_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_accept_s) begin
                s1_q <= s1_d;
            end
            if (s2_adv_s) begin
                prod_q <= prod_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_prod  = prod_q;

`ifdef MULT_CPA_STICKY_EN
    logic sticky_q;

    // Sticky bit travels with the product into stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (s2_adv_s) begin
            sticky_q <= sticky_or(s1_q.lo, STICKY_W);
        end
    end

    assign out_sticky = sticky_q;
`else
    localparam int STICKY_W_UNUSED = STICKY_W;
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mult_final_cpa.sv
// Self-checking bench for mult_final_cpa against a plain-arithmetic reference model.
module tb_mult_final_cpa;

    localparam int W = 64;
`ifdef MULT_CPA_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_prod;
    logic         out_sticky;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;

    logic [W:0] exp_q[$];
    logic [W:0] got_q[$];
    int         got_cyc[$];

    mult_final_cpa dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_prod   (out_prod),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
        logic [W-1:0] p;
        logic [15:0]  low;
        logic         st;
        p   = s + c;
        low = p[15:0];
        st  = STICKY_EN && (low != 16'd0);
        return {st, p};
    endfunction

    // Scoreboard recorder: expected on accept, actual on output handshake
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            got_q.delete();
            got_cyc.delete();
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_sticky, out_prod});
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sum, in_carry));
                acc_cnt++;
            end
        end
        cyc++;
    end

    task automatic rand_pair(output logic [W-1:0] s, output logic [W-1:0] c);
        int mode;
        mode = $urandom_range(0, 3);
        s = {$urandom, $urandom};
        c = {$urandom, $urandom};
        if (mode == 1) begin
            s = {$urandom, 32'hFFFF_FFFF};
            c = {32'd0, 32'd0 + $urandom_range(1, 8)};
        end else if (mode == 2) begin
            s = 64'hFFFF_FFFF_FFFF_FFFF;
            c = {32'd0, $urandom};
        end else begin
            s = s;
        end
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            $display("FAIL %s_count got %0d results expected %0d", name, got_q.size(), exp_q.size());
            errors++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_sum = '0; in_carry = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b expected 0", out_valid); errors++; end
        checks++;
        if (out_prod !== 64'd0) begin $display("FAIL reset_out_prod got %h expected 0", out_prod); errors++; end
        checks++;
        if (out_sticky !== 1'b0) begin $display("FAIL reset_out_sticky got %b expected 0", out_sticky); errors++; end
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b expected 1", in_ready); errors++; end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                                 input logic [W-1:0] exp_p, input logic exp_st);
        out_ready = 1'b1;
        in_valid = 1'b1; in_sum = s; in_carry = c;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin $display("FAIL %s_latency1 out_valid got %b expected 0", name, out_valid); errors++; end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin $display("FAIL %s_latency2 out_valid got %b expected 1", name, out_valid); errors++; end
        checks++;
        if (out_prod !== exp_p) begin $display("FAIL %s_prod got %h expected %h", name, out_prod, exp_p); errors++; end
        checks++;
        if (out_sticky !== exp_st) begin $display("FAIL %s_sticky got %b expected %b", name, out_sticky, exp_st); errors++; end
        @(negedge clk);
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] s, c;
        logic [W:0]   e, g;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_pair(s, c);
            in_valid = 1'b1; in_sum = s; in_carry = c;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin $display("FAIL stream_in_ready beat %0d got %b expected 1", i, in_ready); errors++; end
            @(negedge clk);
        end
        drain("stream");
        for (int i = 0; i < 8 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL stream_data beat %0d got %h expected %h", i, g, e); errors++; end
            if (i > 0) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] !== 1) begin
                    $display("FAIL stream_gap beat %0d got %0d cycles expected 1", i, got_cyc[i] - got_cyc[i-1]);
                    errors++;
                end
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_backpressure;
        logic [W-1:0] ps[12], pc[12];
        logic [W-1:0] held;
        logic [W:0]   e, g;
        int idx, pre, sc;
        for (int i = 0; i < 12; i++) rand_pair(ps[i], pc[i]);
        idx = 0;
        held = '0;
        for (int c = 0; c < 80 && idx < 12; c++) begin
            in_valid = 1'b1; in_sum = ps[idx]; in_carry = pc[idx];
            out_ready = !(c >= 3 && c < 8);
            #1;
            sc = c - 3;
            if (!out_ready) begin
                if (sc == 0) begin
                    held = out_prod;
                    checks++;
                    if (out_valid !== 1'b1) begin $display("FAIL bp_stall_valid got %b expected 1", out_valid); errors++; end
                end else begin
                    checks++;
                    if (out_prod !== held) begin $display("FAIL bp_stable stall %0d got %h expected %h", sc, out_prod, held); errors++; end
                end
                if (sc >= 2) begin
                    checks++;
                    if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready stall %0d got %b expected 0", sc, in_ready); errors++; end
                end
            end
            pre = acc_cnt;
            @(posedge clk); #1;
            if (acc_cnt != pre) idx++;
            @(negedge clk);
        end
        drain("bp");
        checks++;
        if (exp_q.size() !== 12) begin $display("FAIL bp_accepted got %0d expected 12", exp_q.size()); errors++; end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL bp_data got %h expected %h", g, e); errors++; end
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_random;
        logic [W-1:0] s, c;
        logic [W:0]   e, g;
        int pre;
        rand_pair(s, c);
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_sum = s; in_carry = c;
            pre = acc_cnt;
            @(posedge clk); #1;
            if (acc_cnt != pre) rand_pair(s, c);
            @(negedge clk);
        end
        drain("rand");
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL rand_data got %h expected %h", g, e); errors++; end
        end
        exp_q.delete(); got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reset_inflight;
        logic seen;
        out_ready = 1'b0;
        in_valid = 1'b1; in_sum = 64'h1234; in_carry = 64'h1;
        @(negedge clk);
        in_sum = 64'h5678; in_carry = 64'h2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL rstfl_full got valid %b ready %b expected 1 0", out_valid, in_ready); errors++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin $display("FAIL rstfl_out_valid got %b expected 0", out_valid); errors++; end
        checks++;
        if (out_prod !== 64'd0) begin $display("FAIL rstfl_out_prod got %h expected 0", out_prod); errors++; end
        checks++;
        if (in_ready !== 1'b1) begin $display("FAIL rstfl_in_ready got %b expected 1", in_ready); errors++; end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || got_q.size() != 0) begin
            $display("FAIL rstfl_stale got %0d outputs expected 0", got_q.size()); errors++;
        end
    endtask

    initial begin
        test_reset;
        test_directed("cross_split", 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0);
        test_directed("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0);
        test_directed("sticky_set", 64'h10, 64'h0, 64'h10, STICKY_EN);
        test_directed("sticky_clr", 64'h1_0000, 64'h0, 64'h1_0000, 1'b0);
        test_back_to_back;
        test_backpressure;
        test_random;
        test_reset_inflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
